// File: rtl/pwm_multi_core.sv
// rtl/pwm_multi_core.sv - multi-channel phase-shifted PWM core with staged, wrap-aligned updates (option macro: PWM_MULTI_COMP_EN)
module pwm_multi_core #(
   parameter int CH_NUM = 4,
   parameter int CNT_W  = 16,
   parameter int DUTY_W = 10
) (
   input  logic                     CLK_I,
   input  logic                     RSTN_I,
   input  logic [CH_NUM-1:0]        EN_I,
   input  logic [CNT_W-1:0]         PERIOD_I,
   input  logic [CH_NUM*DUTY_W-1:0] DUTY_I,
   input  logic [CH_NUM*CNT_W-1:0]  PHASE_I,
   input  logic                     UPDATE_I,
`ifdef PWM_MULTI_COMP_EN
   input  logic [7:0]               DEAD_I,
   output logic [CH_NUM-1:0]        PWMN_O,
`endif
   output logic [CH_NUM-1:0]        PWM_O,
   output logic                     PERIOD_END_O,
   output logic                     UPD_PEND_O
);

   localparam int                PW        = DUTY_W + CNT_W;
   localparam logic [DUTY_W-1:0] DUTY_FULL = DUTY_W'(1000);
   localparam logic [PW-1:0]     PERMILLE  = PW'(1000);

   // sample stage, multiply stage and pending set
   logic                v_s, v_m, pend_valid, upd_pend;
   logic [CNT_W-1:0]    s_period, pend_period;
   logic [DUTY_W-1:0]   s_duty    [CH_NUM];
   logic [CNT_W-1:0]    s_phase   [CH_NUM];
   logic [PW-1:0]       m_prod    [CH_NUM];
   logic [PW-1:0]       quot      [CH_NUM];
   logic [CNT_W-1:0]    high_sat  [CH_NUM];
   logic [DUTY_W-1:0]   pend_duty [CH_NUM];
   logic [CNT_W-1:0]    pend_high [CH_NUM];
   logic [CNT_W-1:0]    pend_phase[CH_NUM];

   // active set and shared counter
   logic [CNT_W-1:0]    cnt, act_period;
   logic [DUTY_W-1:0]   act_duty  [CH_NUM];
   logic [CNT_W-1:0]    act_high  [CH_NUM];
   logic [CNT_W-1:0]    act_phase [CH_NUM];
   logic [CNT_W:0]      pos       [CH_NUM];
   logic [CH_NUM-1:0]   raw;
   logic                wrap, xfer;

   assign wrap         = (cnt >= act_period - CNT_W'(1));
   // a fresh UPDATE_I on the wrap cycle supersedes the ready set
   assign xfer         = wrap && pend_valid && !UPDATE_I;
   assign PERIOD_END_O = wrap;
   assign UPD_PEND_O   = upd_pend;

   // divide stage: per-mille scaling, saturated to counter width
   always_comb begin
      for (int i = 0; i < CH_NUM; i++) begin
         quot[i]     = m_prod[i] / PERMILLE;
         high_sat[i] = (|quot[i][PW-1:CNT_W]) ? '1 : quot[i][CNT_W-1:0];
      end
   end

   // update pipeline: sample, multiply, divide into pending; a new UPDATE_I restarts it
   always_ff @(posedge CLK_I) begin
      if (!RSTN_I) begin
         v_s         <= 1'b0;
         v_m         <= 1'b0;
         pend_valid  <= 1'b0;
         upd_pend    <= 1'b0;
         s_period    <= CNT_W'(2);
         pend_period <= CNT_W'(2);
         for (int i = 0; i < CH_NUM; i++) begin
            s_duty[i]     <= '0;
            s_phase[i]    <= '0;
            m_prod[i]     <= '0;
            pend_duty[i]  <= '0;
            pend_high[i]  <= '0;
            pend_phase[i] <= '0;
         end
      end else begin
         v_s <= UPDATE_I;
         v_m <= v_s && !UPDATE_I;
         for (int i = 0; i < CH_NUM; i++)
            m_prod[i] <= PW'(s_duty[i]) * PW'(s_period);
         if (UPDATE_I) begin
            pend_valid <= 1'b0;
            upd_pend   <= 1'b1;
            s_period   <= (PERIOD_I < CNT_W'(2)) ? CNT_W'(2) : PERIOD_I;
            for (int i = 0; i < CH_NUM; i++) begin
               s_duty[i]  <= DUTY_I[i*DUTY_W +: DUTY_W];
               s_phase[i] <= PHASE_I[i*CNT_W +: CNT_W];
            end
         end else begin
            if (v_m) begin
               pend_valid  <= 1'b1;
               pend_period <= s_period;
               for (int i = 0; i < CH_NUM; i++) begin
                  pend_duty[i]  <= s_duty[i];
                  pend_high[i]  <= high_sat[i];
                  pend_phase[i] <= s_phase[i];
               end
            end else if (xfer) begin
               pend_valid <= 1'b0;
            end
            if (xfer)
               upd_pend <= 1'b0;
         end
      end
   end

   // counter and atomic transfer of the pending set on the wrap cycle
   always_ff @(posedge CLK_I) begin
      if (!RSTN_I) begin
         cnt        <= '0;
         act_period <= CNT_W'(2);
         for (int i = 0; i < CH_NUM; i++) begin
            act_duty[i]  <= '0;
            act_high[i]  <= '0;
            act_phase[i] <= '0;
         end
      end else if (xfer) begin
         cnt        <= '0;
         act_period <= pend_period;
         for (int i = 0; i < CH_NUM; i++) begin
            act_duty[i]  <= pend_duty[i];
            act_high[i]  <= pend_high[i];
            act_phase[i] <= pend_phase[i];
         end
      end else if (wrap) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + CNT_W'(1);
      end
   end

   // per-channel position within the period and raw level
   always_comb begin
      for (int i = 0; i < CH_NUM; i++) begin
         pos[i] = {1'b0, cnt} + {1'b0, act_period}
                  - ((act_phase[i] >= act_period) ? '0 : {1'b0, act_phase[i]});
         if (pos[i] >= {1'b0, act_period})
            pos[i] = pos[i] - {1'b0, act_period};
         raw[i] = EN_I[i] && (act_duty[i] != '0)
                  && ((act_duty[i] >= DUTY_FULL)
                      || ((act_high[i] != '0)
                          && ((act_high[i] >= act_period) || (pos[i] < {1'b0, act_high[i]}))));
      end
   end

`ifdef PWM_MULTI_COMP_EN
   logic [7:0]        s_dead, pend_dead, act_dead;
   logic [7:0]        dcnt [CH_NUM];
   logic [7:0]        dnext[CH_NUM];
   logic [CH_NUM-1:0] raw_q;

   // dead-time value follows the same sample/pending/active path as the rest of the set
   always_ff @(posedge CLK_I) begin
      if (!RSTN_I) begin
         s_dead    <= '0;
         pend_dead <= '0;
         act_dead  <= '0;
      end else begin
         if (UPDATE_I)
            s_dead <= DEAD_I;
         else if (v_m)
            pend_dead <= s_dead;
         if (xfer)
            act_dead <= pend_dead;
      end
   end

   // every raw edge reloads the dead-time counter
   always_comb begin
      for (int i = 0; i < CH_NUM; i++)
         dnext[i] = (raw[i] != raw_q[i]) ? act_dead
                  : ((dcnt[i] != 8'd0) ? dcnt[i] - 8'd1 : 8'd0);
   end

   // complementary outputs, both held low while dead time runs
   always_ff @(posedge CLK_I) begin
      if (!RSTN_I) begin
         raw_q  <= '0;
         PWM_O  <= '0;
         PWMN_O <= '0;
         for (int i = 0; i < CH_NUM; i++)
            dcnt[i] <= '0;
      end else begin
         raw_q <= raw;
         for (int i = 0; i < CH_NUM; i++) begin
            dcnt[i]   <= dnext[i];
            PWM_O[i]  <= raw[i] && (dnext[i] == 8'd0);
            PWMN_O[i] <= EN_I[i] && !raw[i] && (dnext[i] == 8'd0);
         end
      end
   end
`else
   // registered outputs, one cycle behind the counter value they reflect
   always_ff @(posedge CLK_I) begin
      if (!RSTN_I)
         PWM_O <= '0;
      else
         PWM_O <= raw;
   end
`endif

endmodule
